// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter for fetch and data sides.
// Data has priority; a watchdog aborts accesses that are never acked.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic [5:0]  stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    D_BUSY
  } state_t;

  localparam logic [7:0] LP_LAST =
    (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_ce;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [31:0] r_if_data;
  logic [31:0] r_d_rdata;

  logic        w_busy;
  logic        w_tmo;
  logic        w_done;
  logic        w_if_done;
  logic        w_d_done;
  logic        w_d_rd_done;
  logic [31:0] w_rdata;
  logic        w_load_if;
  logic        w_load_d;
  logic        w_fetch_wait;
  logic        w_data_wait;

  assign w_busy = (r_state != IDLE);

  // Ack wins over a simultaneous timeout, so timeout implies no ack.
  assign w_tmo = (TIMEOUT != 0) && w_busy && !mem_ack_i
                 && (r_cnt == LP_LAST);

  assign w_done      = w_busy && (mem_ack_i || w_tmo);
  assign w_if_done   = (r_state == IF_BUSY) && w_done;
  assign w_d_done    = (r_state == D_BUSY) && w_done;
  assign w_d_rd_done = w_d_done && !r_we;
  assign w_rdata     = mem_ack_i ? mem_data_i : 32'h0;

  // The requester being completed is served; only the other side
  // can chain straight into a new access.
  always_comb begin
    w_next    = r_state;
    w_load_if = 1'b0;
    w_load_d  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (d_req_i) begin
          w_load_d = 1'b1;
          w_next   = D_BUSY;
        end else if (if_req_i) begin
          w_load_if = 1'b1;
          w_next    = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (w_done) begin
          if (d_req_i) begin
            w_load_d = 1'b1;
            w_next   = D_BUSY;
          end else begin
            w_next = IDLE;
          end
        end
      end
      D_BUSY: begin
        if (w_done) begin
          if (if_req_i) begin
            w_load_if = 1'b1;
            w_next    = IF_BUSY;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_ce      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'h0;
      r_sel     <= 4'h0;
      r_wdata   <= 32'h0;
      r_if_data <= 32'h0;
      r_d_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_load_d) begin
        r_ce    <= 1'b1;
        r_we    <= d_we_i;
        r_addr  <= d_addr_i;
        r_sel   <= d_sel_i;
        r_wdata <= d_wdata_i;
        r_cnt   <= 8'd0;
      end else if (w_load_if) begin
        r_ce   <= 1'b1;
        r_we   <= 1'b0;
        r_addr <= if_addr_i;
        r_sel  <= 4'hF;
        r_cnt  <= 8'd0;
      end else if (w_done) begin
        r_ce <= 1'b0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_if_done) begin
        r_if_data <= w_rdata;
      end
      if (w_d_rd_done) begin
        r_d_rdata <= w_rdata;
      end
    end
  end

  assign w_fetch_wait = if_req_i && !w_if_done;
  assign w_data_wait  = d_req_i && !w_d_done;

  always_comb begin
    stall_o = 6'b000000;
    if (!rst) begin
      if (w_data_wait) begin
        stall_o = 6'b011111;
      end else if (w_fetch_wait) begin
        stall_o = 6'b000111;
      end
    end
  end

  assign if_data_o = (w_if_done && !rst) ? w_rdata : r_if_data;
  assign d_rdata_o = (w_d_rd_done && !rst) ? w_rdata : r_d_rdata;
  assign err_o     = w_tmo && !rst;

  assign mem_ce_o    = r_ce;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_sel_o   = r_sel;
  assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: per-cycle vector table fed through a
// scoreboard queue, plus hand-written timeout and reset sequences.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic [5:0]  stall_o;
  logic        err_o;

  mem_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .if_req_i(if_req_i),
    .if_addr_i(if_addr_i),
    .if_data_o(if_data_o),
    .d_req_i(d_req_i),
    .d_we_i(d_we_i),
    .d_addr_i(d_addr_i),
    .d_sel_i(d_sel_i),
    .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o),
    .mem_ce_o(mem_ce_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i),
    .stall_o(stall_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [3:0]  ds;
    logic [31:0] dwd;
    logic [31:0] md;
    logic        ak;
  } in_t;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] ad;
    logic [3:0]  sl;
    logic [31:0] wd;
    logic [31:0] ifd;
    logic [31:0] drd;
    logic [5:0]  st;
    logic        er;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam logic [5:0] S_D = 6'b011111;
  localparam logic [5:0] S_F = 6'b000111;
  localparam int NV = 18;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl [NV];
  out_t sb_q [$];

  function automatic vec_t V(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [3:0] ds,
    input logic [31:0] dwd, input logic [31:0] md,
    input logic ak,
    input logic ce, input logic we,
    input logic [31:0] ad, input logic [3:0] sl,
    input logic [31:0] wd, input logic [31:0] ifd,
    input logic [31:0] drd, input logic [5:0] st,
    input logic er);
    vec_t v;
    v.i = '{ir, ia, dr, dw, da, ds, dwd, md, ak};
    v.o = '{ce, we, ad, sl, wd, ifd, drd, st, er};
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.ce  = mem_ce_o;
    o.we  = mem_we_o;
    o.ad  = mem_addr_o;
    o.sl  = mem_sel_o;
    o.wd  = mem_wdata_o;
    o.ifd = if_data_o;
    o.drd = d_rdata_o;
    o.st  = stall_o;
    o.er  = err_o;
    return o;
  endfunction

  task automatic drive(input in_t v);
    if_req_i   = v.ir;
    if_addr_i  = v.ia;
    d_req_i    = v.dr;
    d_we_i     = v.dw;
    d_addr_i   = v.da;
    d_sel_i    = v.ds;
    d_wdata_i  = v.dwd;
    mem_data_i = v.md;
    mem_ack_i  = v.ak;
  endtask

  task automatic step(input in_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  in_t  idle_in;
  in_t  cur;
  out_t exp_o;

  initial begin
    idle_in = '0;
    // ir ia dr dw da ds dwd md ak | ce we ad sl wd ifd drd st er
    tbl[0]  = V(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    tbl[1]  = V(1,4,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,S_F,0);
    tbl[2]  = V(1,4,0,0,0,0,0,32'h34011100,1,
                1,0,4,4'hF,0,32'h34011100,0,0,0);
    tbl[3]  = V(0,0,0,0,0,0,0,0,0,
                0,0,4,4'hF,0,32'h34011100,0,0,0);
    tbl[4]  = V(1,8,1,1,32'h100,4'b0011,32'hDEADBEEF,0,0,
                0,0,4,4'hF,0,32'h34011100,0,S_D,0);
    tbl[5]  = V(1,8,1,1,32'h100,4'b0011,32'hDEADBEEF,0,0,
                1,1,32'h100,4'b0011,32'hDEADBEEF,32'h34011100,0,S_D,0);
    tbl[6]  = tbl[5];
    tbl[7]  = V(1,8,1,1,32'h100,4'b0011,32'hDEADBEEF,32'hAAAA5555,1,
                1,1,32'h100,4'b0011,32'hDEADBEEF,32'h34011100,0,S_F,0);
    tbl[8]  = V(1,8,0,0,0,0,0,0,0,
                1,0,8,4'hF,32'hDEADBEEF,32'h34011100,0,S_F,0);
    tbl[9]  = tbl[8];
    tbl[10] = V(1,8,0,0,0,0,0,32'h13,1,
                1,0,8,4'hF,32'hDEADBEEF,32'h13,0,0,0);
    tbl[11] = V(0,0,0,0,0,0,0,0,0,
                0,0,8,4'hF,32'hDEADBEEF,32'h13,0,0,0);
    tbl[12] = V(1,32'hC,0,0,0,0,0,0,0,
                0,0,8,4'hF,32'hDEADBEEF,32'h13,0,S_F,0);
    tbl[13] = V(1,32'hC,1,0,32'h200,4'hF,0,0,0,
                1,0,32'hC,4'hF,32'hDEADBEEF,32'h13,0,S_D,0);
    tbl[14] = V(1,32'hC,1,0,32'h200,4'hF,0,32'h20000001,1,
                1,0,32'hC,4'hF,32'hDEADBEEF,32'h20000001,0,S_D,0);
    tbl[15] = V(0,0,1,0,32'h200,4'hF,0,0,0,
                1,0,32'h200,4'hF,0,32'h20000001,0,S_D,0);
    tbl[16] = V(0,0,1,0,32'h200,4'hF,0,32'h12345678,1,
                1,0,32'h200,4'hF,0,32'h20000001,32'h12345678,0,0);
    tbl[17] = V(0,0,0,0,0,0,0,0,0,
                0,0,32'h200,4'hF,0,32'h20000001,32'h12345678,0,0);

    rst = 1'b1;
    drive(idle_in);
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(tbl[k].i);
      sb_q.push_back(tbl[k].o);
      @(negedge clk);
      exp_o = sb_q.pop_front();
      chk($sformatf("row%0d", k), 160'(sample()), 160'(exp_o));
    end

    // watchdog: read with no ack aborts on the 4th busy cycle
    cur = idle_in;
    cur.dr = 1'b1;
    cur.da = 32'h300;
    cur.ds = 4'hF;
    step(cur);
    chk("to_req_stall", 160'(stall_o), 160'(S_D));
    for (int b = 1; b <= 3; b++) begin
      step(cur);
      chk($sformatf("to_busy%0d", b),
          160'({mem_ce_o, err_o, stall_o}),
          160'({1'b1, 1'b0, S_D}));
    end
    step(cur);
    chk("to_err", 160'(err_o), 160'(1'b1));
    chk("to_rdata", 160'(d_rdata_o), 160'(32'h0));
    chk("to_stall", 160'(stall_o), 160'(6'b0));
    step(idle_in);
    chk("to_idle", 160'({mem_ce_o, err_o, d_rdata_o}),
        160'({1'b0, 1'b0, 32'h0}));

    // good read to load d_rdata_o before the reset test
    cur.da = 32'h500;
    step(cur);
    cur.ak = 1'b1;
    cur.md = 32'h55AA55AA;
    step(cur);
    chk("rd_ack", 160'(d_rdata_o), 160'(32'h55AA55AA));
    step(idle_in);
    chk("rd_hold", 160'(d_rdata_o), 160'(32'h55AA55AA));

    // reset mid-access drops the access without capture or err
    cur = idle_in;
    cur.dr = 1'b1;
    cur.da = 32'h400;
    cur.ds = 4'hF;
    step(cur);
    step(cur);
    chk("rs_busy", 160'({mem_ce_o, mem_addr_o}),
        160'({1'b1, 32'h400}));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cur.ak = 1'b1;
    cur.md = 32'hCAFEF00D;
    drive(cur);
    @(negedge clk);
    chk("rs_err", 160'({err_o, stall_o}), 160'({1'b0, 6'b0}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle_in);
    @(negedge clk);
    chk("rs_after",
        160'({mem_ce_o, stall_o, err_o, d_rdata_o}),
        160'({1'b0, 6'b0, 1'b0, 32'h0}));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
